shift_reg_reader: RTL and testbench

Circular sample-history buffer in inferred block RAM, with a triggered stream-out read port. A continuous input stream is written into a LEN-deep ring. On trigger, the last LEN samples are played out oldest-first over a valid/ready handshake. This is the capture/readback end for a fixed-length delay history; it feeds downstream consumers such as FFT loaders and host readback.

---
 rtl/shift_reg_reader.sv | 204 ++++++++++++++++++++
 tb/tb_shift_reg_reader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_reader.sv
// -----------------------------------------------------------------------------
// shift_reg_reader
//
// Circular sample-history buffer held in an inferred block RAM, with a
// triggered stream-out port. Incoming samples are written continuously into a
// LEN-deep ring. When a trigger is accepted, the most recent LEN samples are
// played out oldest-first over a valid/ready handshake. The ring is frozen
// while a readout is in progress.
//
// Parameters:
//   DATA_WIDTH  sample width in bits
//   LEN         ring depth in samples (>= 2, need not be a power of two)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   di         input sample
//   di_valid   write di this cycle (ignored while a readout is running)
//   trig       single-cycle readout request (accepted only when idle and filled)
//   filled     ring holds LEN valid samples since reset
//   busy       readout in progress
//   data_o     readout sample
//   do_valid   data_o is valid
//   do_ready   consumer accepts data_o
//   do_last    marks the LEN-th (newest) beat of a readout
//   drop_cnt   samples discarded during readouts (saturating, 16 bit)
//
// Optional feature macro: SHIFT_REG_READER_DROP_CNT_EN
//   When defined, the drop_cnt port and its counter are present. It clears on
//   trigger acceptance and on reset, and holds its value once idle again.
// -----------------------------------------------------------------------------
module shift_reg_reader #(
  parameter int DATA_WIDTH = 25,
  parameter int LEN        = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic                  di_valid,
  input  logic                  trig,
  output logic                  filled,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  do_valid,
  input  logic                  do_ready,
  output logic                  do_last
`ifdef SHIFT_REG_READER_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int AW = $clog2(LEN);
  localparam int CW = $clog2(LEN + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]         wr_addr, wr_addr_nxt;
  logic [AW-1:0]         rd_addr;
  logic [CW-1:0]         count, count_nxt;
  logic [CW-1:0]         beat_cnt;
  logic [DATA_WIDTH-1:0] rd_data;

  logic wr_en;
  logic accept;
  logic load;
  logic finish;
  logic rd_en;

  logic [DATA_WIDTH-1:0] mem [LEN];

  // Ring addresses wrap explicitly so LEN need not be a power of two.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_en       = 1'b0;
    accept      = 1'b0;
    load        = 1'b0;
    finish      = 1'b0;
    wr_addr_nxt = wr_addr;
    count_nxt   = count;
    state_nxt   = state;

    // Writes only happen while idle; during a readout the ring is frozen.
    wr_en = (state == IDLE) && di_valid;
    if (wr_en) begin
      wr_addr_nxt = next_addr(wr_addr);
      if (count != FULL_CNT) count_nxt = count + 1'b1;
    end

    accept = (state == IDLE) && trig && filled;

    // The output register is a one-deep pipeline stage: it refills whenever it
    // is empty or being drained, except when the beat leaving is the last one.
    finish = (state == STREAM) && do_valid && do_ready && do_last;
    load   = (state == STREAM) && !finish && (!do_valid || do_ready);

    unique case (state)
      IDLE:    if (accept) state_nxt = PRIME;
      PRIME:   state_nxt = STREAM;
      STREAM:  if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // PRIME pre-fetches the oldest sample; each output load fetches the next.
  assign rd_en = (state == PRIME) || load;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Datapath and handshake registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      count    <= '0;
      filled   <= 1'b0;
      busy     <= 1'b0;
      beat_cnt <= '0;
      data_o   <= '0;
      do_valid <= 1'b0;
      do_last  <= 1'b0;
    end else begin
      wr_addr <= wr_addr_nxt;
      count   <= count_nxt;
      filled  <= (count_nxt == FULL_CNT);

      if (accept) begin
        // The slot after the newest sample (including one written this very
        // cycle) holds the oldest sample of the history.
        rd_addr  <= wr_addr_nxt;
        busy     <= 1'b1;
        beat_cnt <= '0;
      end else if (rd_en) begin
        rd_addr <= next_addr(rd_addr);
      end

      if (load) begin
        data_o   <= rd_data;
        do_valid <= 1'b1;
        do_last  <= (beat_cnt == LAST_BEAT);
        beat_cnt <= beat_cnt + 1'b1;
      end else if (finish) begin
        do_valid <= 1'b0;
        do_last  <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample ring
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array and its read register carry no reset; a reset would
  // prevent block-RAM inference, and stale contents are never exposed because
  // the sample count restarts from zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= di;
    if (rd_en) rd_data <= mem[rd_addr];
  end

`ifdef SHIFT_REG_READER_DROP_CNT_EN
  // ---------------------------------------------------------------------------
  // Dropped-sample counter: di_valid cycles that arrive while a readout runs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (accept) begin
      drop_cnt <= '0;
    end else if ((state != IDLE) && di_valid && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_reg_reader.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_reader
//
// Self-checking bench for shift_reg_reader (DATA_WIDTH=8, LEN=8). The stimulus
// process drives inputs and updates a sample-history model; when it predicts
// trigger acceptance it pushes the expected LEN beats into a scoreboard queue.
// A monitor on the falling edge pops and compares every accepted beat, and
// also checks filled/busy, trigger latency and output stability under
// back-pressure.
// -----------------------------------------------------------------------------
module tb_shift_reg_reader;

  localparam int DW  = 8;
  localparam int LEN = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] di = '0;
  logic          di_valid = 1'b0;
  logic          trig = 1'b0;
  logic          filled;
  logic          busy;
  logic [DW-1:0] data_o;
  logic          do_valid;
  logic          do_ready = 1'b1;
  logic          do_last;
`ifdef SHIFT_REG_READER_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  shift_reg_reader #(
    .DATA_WIDTH (DW),
    .LEN        (LEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .di       (di),
    .di_valid (di_valid),
    .trig     (trig),
    .filled   (filled),
    .busy     (busy),
    .data_o   (data_o),
    .do_valid (do_valid),
    .do_ready (do_ready),
    .do_last  (do_last)
`ifdef SHIFT_REG_READER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: history of written samples plus readout bookkeeping
  // ---------------------------------------------------------------------------
  logic [DW-1:0] hist[$];
  beat_t         exp_q[$];
  int            m_count   = 0;
  bit            m_busy    = 0;
  int            m_age     = 0;
  int            m_drop    = 0;
  bit            done_seen = 0;

  int ready_mode = 0;  // 0: always ready, 1: alternate, 2: random
  bit phase      = 0;

  task automatic model_clear();
    hist.delete();
    exp_q.delete();
    m_count   = 0;
    m_busy    = 0;
    m_age     = 0;
    m_drop    = 0;
    done_seen = 0;
  endtask

  // Effect of one rising edge given the inputs that were applied before it.
  task automatic model_edge(input bit dv, input logic [DW-1:0] d, input bit tr);
    bit acc;
    if (!m_busy) begin
      acc = tr && (m_count == LEN);
      if (dv) begin
        hist.push_back(d);
        if (hist.size() > LEN) hist.delete(0);
        if (m_count < LEN) m_count++;
      end
      if (acc) begin
        for (int i = 0; i < LEN; i++) begin
          beat_t b;
          b.data = hist[i];
          b.last = (i == LEN - 1);
          exp_q.push_back(b);
        end
        m_busy = 1;
        m_age  = 0;
        m_drop = 0;
      end
    end else begin
      if (dv && m_drop != 16'hFFFF) m_drop++;
      if (m_age < 3) m_age++;
      if (done_seen) begin
        m_busy    = 0;
        done_seen = 0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic step(input bit dv, input logic [DW-1:0] d, input bit tr);
    bit rdy;
    case (ready_mode)
      1: begin
        if (!do_valid) begin
          phase = 0;
          rdy   = 1;
        end else begin
          rdy   = (phase == 0);
          phase = ~phase;
        end
      end
      2:       rdy = ($urandom_range(0, 3) != 0);
      default: rdy = 1;
    endcase
    di_valid = dv;
    di       = d;
    trig     = tr;
    do_ready = rdy;
    @(posedge clk);
    model_edge(dv, d, tr);
    #1;
    di_valid = 0;
    trig     = 0;
  endtask

  task automatic write_seq(input int first, input int n);
    for (int i = 0; i < n; i++) step(1, DW'(first + i), 0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (m_busy && guard < 200) begin
      step(0, '0, 0);
      guard++;
    end
    check("readout_timeout_busy", busy, 0);
  endtask

  task automatic apply_reset();
    #2 rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  int            cyc        = 0;
  int            first_cyc  = -1;
  int            last_span  = -1;
  int            beats_seen = 0;
  bit            hold_prev  = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 0;
      first_cyc = -1;
    end else begin
      cyc++;
      check("filled", filled, (m_count == LEN));
      check("busy", busy, m_busy);
`ifdef SHIFT_REG_READER_DROP_CNT_EN
      check("drop_cnt", drop_cnt, m_drop);
`endif
      if (!m_busy) check("idle_valid", do_valid, 0);
      if (m_busy && m_age <= 2) check("trig_latency", do_valid, (m_age == 2));
      if (hold_prev) begin
        check("hold_valid", do_valid, 1);
        check("hold_data", data_o, prev_data);
        check("hold_last", do_last, prev_last);
      end
      if (do_valid && first_cyc < 0) first_cyc = cyc;
      if (do_valid && do_ready) begin
        check("beat_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", data_o, b.data);
          check("beat_last", do_last, b.last);
        end
        beats_seen++;
        if (do_last) begin
          done_seen = 1;
          last_span = cyc - first_cyc;
          first_cyc = -1;
        end
      end
      hold_prev = do_valid && !do_ready;
      prev_data = data_o;
      prev_last = do_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int base;
    int guard;

    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    check("reset_filled", filled, 0);
    check("reset_busy", busy, 0);
    check("reset_valid", do_valid, 0);
    check("reset_last", do_last, 0);
    check("reset_data", data_o, 0);

    // 1: write 1..8, stream 1..8 at full rate
    ready_mode = 0;
    write_seq(1, LEN);
    step(0, '0, 1);
    wait_idle();

    // 2: wrap the ring, stream 4..11
    apply_reset();
    write_seq(1, 11);
    step(0, '0, 1);
    wait_idle();

    // 3: alternating ready; 15 cycles from first valid to last handshake
    apply_reset();
    write_seq(1, LEN);
    ready_mode = 1;
    step(0, '0, 1);
    wait_idle();
    check("alt_ready_span", last_span, 14);
    ready_mode = 0;

    // 4: trig before filled is ignored, then stream 1..8
    apply_reset();
    write_seq(1, 5);
    step(0, '0, 1);
    step(0, '0, 0);
    check("early_trig_busy", busy, 0);
    check("early_trig_valid", do_valid, 0);
    write_seq(6, 3);
    step(0, '0, 1);
    wait_idle();

    // 5: trig coincident with a write, drops during readout, repeat readout
    apply_reset();
    write_seq(1, LEN);
    step(1, 8'd9, 1);
    step(1, 8'd20, 0);
    step(1, 8'd21, 0);
    step(1, 8'd22, 0);
    wait_idle();
`ifdef SHIFT_REG_READER_DROP_CNT_EN
    check("drop_cnt_after_readout", drop_cnt, 3);
`endif
    step(0, '0, 1);
    wait_idle();

    // 6: asynchronous reset after the 3rd beat aborts the readout
    apply_reset();
    write_seq(1, LEN);
    base = beats_seen;
    step(0, '0, 1);
    guard = 0;
    while (beats_seen < base + 3 && guard < 50) begin
      step(0, '0, 0);
      guard++;
    end
    check("arst_pre_valid", do_valid, 1);
    #2 rst_n = 0;
    #1;
    check("arst_valid", do_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_filled", filled, 0);
    check("arst_last", do_last, 0);
    check("arst_data", data_o, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    write_seq(40, LEN - 1);
    step(0, '0, 1);
    step(0, '0, 0);
    check("post_arst_trig_ignored", busy, 0);
    write_seq(40 + LEN - 1, 1);
    step(0, '0, 1);
    wait_idle();

    // Random soak: random writes, triggers and back-pressure
    ready_mode = 2;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 7) == 0);
    end
    wait_idle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
